// File: rtl/ctrl_lectura_rtc.sv
// ctrl_lectura_rtc
// Sweeps the RTC register file from FIRST_ADDR to LAST_ADDR. Each address is
// read with a 4-phase rd_req/rd_ack handshake to the bus-cycle controller.
// The returned bytes are captured into the seg/min/hora/dia/mes/anio registers.
// If rd_ack does not arrive within TIMEOUT cycles, the sweep is abandoned and
// the sticky err flag is set.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-low reset
//   start_rd  one-cycle sweep request; only accepted in IDLE
//   rd_ack    bus-cycle acknowledge; dato_in is valid while it is high
//   dato_in   byte returned by the RTC bus cycle
//   Addr_L    read address to the address mux
//   rd_req    read request to the bus-cycle controller
//   busy      sweep in progress
//   done      one-cycle pulse when a sweep completes without error
//   err       sticky timeout flag, cleared by the next accepted start_rd
//   seg..anio captured BCD time/date bytes (offsets 0..5 from FIRST_ADDR)
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start_rd; Addr_L holds its last value
// ST_REQ     | rd_req high, waiting for rd_ack, timer running
// ST_RELEASE | data captured, waiting for rd_ack to return low
// ST_DONE    | done pulse cycle
// ST_ERR     | timeout cycle, err already set; back to IDLE next

module ctrl_lectura_rtc #(
  parameter logic [3:0] FIRST_ADDR = 4'h1,
  parameter logic [3:0] LAST_ADDR  = 4'h6,
  parameter logic [7:0] TIMEOUT    = 8'd200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_rd,
  input  logic       rd_ack,
  input  logic [7:0] dato_in,
  output logic [3:0] Addr_L,
  output logic       rd_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  // Last timer value before giving up; the timer never counts past it.
  localparam logic [7:0] TIMER_LAST = TIMEOUT - 8'd1;

  logic [2:0] state;
  logic [7:0] timer;
  logic [3:0] offset;

  // Offsets outside 0..5 complete the handshake but write no register.
  assign offset = Addr_L - FIRST_ADDR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      timer  <= 8'd0;
      Addr_L <= 4'h0;
      rd_req <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      seg    <= 8'h00;
      min    <= 8'h00;
      hora   <= 8'h00;
      dia    <= 8'h00;
      mes    <= 8'h00;
      anio   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rd) begin
            state  <= ST_REQ;
            Addr_L <= FIRST_ADDR;
            rd_req <= 1'b1;
            busy   <= 1'b1;
            err    <= 1'b0;
            timer  <= 8'd0;
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            case (offset)
              4'd0:    seg  <= dato_in;
              4'd1:    min  <= dato_in;
              4'd2:    hora <= dato_in;
              4'd3:    dia  <= dato_in;
              4'd4:    mes  <= dato_in;
              4'd5:    anio <= dato_in;
              default: ;
            endcase
            rd_req <= 1'b0;
            state  <= ST_RELEASE;
          end else if (timer == TIMER_LAST) begin
            // err/busy are set on entry so they are already visible in ST_ERR.
            rd_req <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
            state  <= ST_ERR;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (!rd_ack) begin
            if (Addr_L == LAST_ADDR) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              Addr_L <= Addr_L + 4'd1;
              timer  <= 8'd0;
              rd_req <= 1'b1;
              state  <= ST_REQ;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
